// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_regfile
//  Brief    : APB completer with NUM_REGS byte-strobed word registers, fixed
//             wait states and pslverr on misaligned/out-of-range accesses.
//  Revision : 1.0  initial release
// ============================================================================
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic [2:0]            pprot,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [3:0]            pstrb,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int                  c_IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-3:0] c_NREGS = (ADDR_WIDTH-2)'(NUM_REGS);
    localparam logic [3:0]          c_WAIT    = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                r_state;
    logic [3:0]            r_wait_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_wr;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [ADDR_WIDTH-3:0] w_index;
    logic                  w_addr_err;
    logic                  w_complete;
    logic                  w_unused;

    // The full upper address is the index, so any high bit set lands out of range.
    assign w_index    = paddr[ADDR_WIDTH-1:2];
    assign w_addr_err = (paddr[1:0] != 2'b00) || (w_index >= c_NREGS);
    assign w_unused   = &{1'b0, pprot};

    assign w_complete = (r_state == S_ACCESS) && psel && penable && (r_wait_cnt == c_WAIT);

    assign pready  = w_complete;
    assign pslverr = w_complete & r_err;
    assign prdata  = (w_complete && !r_wr && !r_err) ? r_regs[r_idx] : '0;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_idx      <= '0;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (psel && !penable) begin
                        r_idx      <= w_index[c_IDX_W-1:0];
                        r_wr       <= pwrite;
                        r_err      <= w_addr_err;
                        r_wait_cnt <= 4'd0;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!psel) begin
                        r_state <= S_IDLE;
                    end else if (penable) begin
                        if (r_wait_cnt == c_WAIT) begin
                            r_state <= S_IDLE;
                            if (r_wr && !r_err) begin
                                for (int i = 0; i < 4; i++) begin
                                    if (pstrb[i]) begin
                                        r_regs[r_idx][8*i +: 8] <= pwdata[8*i +: 8];
                                    end
                                end
                            end
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_slave_regfile
//  Brief    : Self-checking bench for apb_slave_regfile (WAIT_STATES 1 and 0).
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_slave_regfile;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel0, psel1, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(1)) u_dut1 (
        .pclk(pclk), .preset(preset), .psel(psel1), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(0)) u_dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    int          which_dut = 1;
    logic        cur_pready, cur_pslverr;
    logic [31:0] cur_prdata;

    always_comb begin
        cur_pready  = (which_dut == 1) ? pready1  : pready0;
        cur_pslverr = (which_dut == 1) ? pslverr1 : pslverr0;
        cur_prdata  = (which_dut == 1) ? prdata1  : prdata0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    // Entered and left on a falling edge; the next call may start a setup phase right away.
    task automatic apb_xfer(input int which, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        exp_t x;
        int   cyc;
        bit   done;
        e.rdata = wr ? 32'h0 : exp_rdata;
        e.err   = exp_err;
        e.lat   = (which == 1) ? 2 : 1;
        sb.push_back(e);
        which_dut = which;
        psel0   = (which == 0);
        psel1   = (which == 1);
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        pstrb   = strb;
        @(negedge pclk);
        penable = 1'b1;
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc <= 20) begin
            #1;
            if (cur_pready) begin
                x = sb.pop_front();
                check("prdata", cur_prdata, x.rdata);
                check("pslverr", {31'b0, cur_pslverr}, {31'b0, x.err});
                check("latency", cyc, x.lat);
                done = 1'b1;
            end else begin
                check("pslverr_wait", {31'b0, cur_pslverr}, 32'h0);
                check("prdata_wait", cur_prdata, 32'h0);
                cyc++;
            end
            @(negedge pclk);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: pready never rose for addr 0x%08h, expected it within 20 cycles", addr);
            void'(sb.pop_front());
        end
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'h0000_000C, 32'h1234_5678, 4'b1010, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_000C, 32'h0,         4'b1111, 32'h12FF_56FF, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'b1111, 32'h0,         1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 4'b1111, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hA5A5_A5A5, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0006, 32'h0,         4'b0000, 32'h0,         1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hA5A5_A5A5, 1'b0};
        vecs[10] = '{1'b1, 32'h4000_0010, 32'h2222_2222, 4'b1111, 32'h0,         1'b1};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hA5A5_A5A5, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_001C, 32'h3333_3333, 4'b0000, 32'h0,         1'b0};
        vecs[13] = '{1'b0, 32'h0000_001C, 32'h0,         4'b0000, 32'h0,         1'b0};
        vecs[14] = '{1'b0, 32'h0000_0020, 32'h0,         4'b0000, 32'h0,         1'b1};

        preset = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b010;
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        #1;
        check("rst_pready1",  {31'b0, pready1},  32'h0);
        check("rst_pslverr1", {31'b0, pslverr1}, 32'h0);
        check("rst_prdata1",  prdata1,           32'h0);
        check("rst_pready0",  {31'b0, pready0},  32'h0);
        @(negedge pclk);

        for (int i = 0; i < 15; i++) begin
            apb_xfer(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                     vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Abort: psel dropped in the first access cycle of a write to 0x10.
        which_dut = 1;
        psel1 = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1;
        pwdata = 32'h0BAD_F00D; pstrb = 4'b1111;
        @(negedge pclk);
        penable = 1'b1;
        #1 check("abort_pready_acc1", {31'b0, pready1}, 32'h0);
        @(negedge pclk);
        psel1 = 1'b0; penable = 1'b0;
        #1 check("abort_pready_after", {31'b0, pready1}, 32'h0);
        @(negedge pclk);
        #1 check("abort_pready_idle", {31'b0, pready1}, 32'h0);
        @(negedge pclk);
        apb_xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0);

        // penable without a setup phase must not start a transfer.
        psel1 = 1'b1; penable = 1'b1; paddr = 32'h4; pwrite = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check("protviol_pready", {31'b0, pready1}, 32'h0);
            @(negedge pclk);
        end
        psel1 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        apb_xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // Reset lands on what would have been the completing edge of a write.
        psel1 = 1'b1; penable = 1'b0; paddr = 32'h4; pwrite = 1'b1;
        pwdata = 32'h7777_7777; pstrb = 4'b1111;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0; psel1 = 1'b0; penable = 1'b0;
        #1;
        check("postrst_pready",  {31'b0, pready1},  32'h0);
        check("postrst_pslverr", {31'b0, pslverr1}, 32'h0);
        check("postrst_prdata",  prdata1,           32'h0);
        @(negedge pclk);
        apb_xfer(1, 1'b0, 32'h4,  32'h0, 4'h0, 32'h0, 1'b0);
        apb_xfer(1, 1'b0, 32'hC,  32'h0, 4'h0, 32'h0, 1'b0);
        apb_xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);

        // Zero-wait instance: back-to-back write then read.
        apb_xfer(0, 1'b1, 32'h8, 32'hCAFE_BABE, 4'b1111, 32'h0,         1'b0);
        apb_xfer(0, 1'b0, 32'h8, 32'h0,         4'b0000, 32'hCAFE_BABE, 1'b0);
        apb_xfer(0, 1'b0, 32'h7, 32'h0,         4'b0000, 32'h0,         1'b1);
        apb_xfer(0, 1'b0, 32'h4, 32'h0,         4'b0000, 32'h0,         1'b0);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB completer sitting directly downstream of apb_master, on one psel line from the master's select bus. It implements a bank of NUM_REGS word-wide registers, with:
- byte-strobed writes;
- a fixed, parameterised number of wait states;
- pslverr on illegal accesses.
Four instances (one per psel bit) form the slave side of the bus.

Parameters:
ADDR_WIDTH, 32, paddr width
DATA_WIDTH, 32, data width; fixed at 32 (pstrb is 4 bits)
NUM_REGS, 8, number of 32-bit registers; legal word index 0..NUM_REGS-1
WAIT_STATES, 1, access cycles with pready low before completion (0..15)

Ports:
pclk  in  1  bus clock; all logic on rising edge
preset  in  1  synchronous, active-high reset
psel  in  1  select for this completer
penable  in  1  access phase indicator
paddr  in  ADDR_WIDTH  byte address
pwrite  in  1  1 = write, 0 = read
pprot  in  3  protection attributes; accepted, not checked
pwdata  in  32  write data
pstrb  in  4  byte-lane write strobes
prdata  out  32  read data
pready  out  1  transfer complete
pslverr  out  1  transfer error, valid only with pready

Behaviour:
Reset:
- Synchronous, active-high on preset. On a preset cycle: all registers = 0, state = IDLE, wait_cnt = 0, err flag = 0.
- Outputs the following cycle: prdata = 0, pready = 0, pslverr = 0.
- preset has priority over any in-flight transfer. An aborted write is never committed.

FSM states: IDLE, ACCESS.
- IDLE: when psel=1 and penable=0 (setup phase), at the clock edge:
  - latch index = paddr[ADDR_WIDTH-1:2];
  - latch pwrite;
  - compute err = (paddr[1:0] != 0) or (index >= NUM_REGS);
  - wait_cnt = 0;
  - go to ACCESS.
  - psel=1 with penable=1 while in IDLE is a protocol violation: stay in IDLE, pready stays 0.
- ACCESS with psel=1, penable=1:
  - if wait_cnt < WAIT_STATES: wait_cnt increments, pready=0;
  - if wait_cnt == WAIT_STATES: pready=1 (combinational from state/counter). At that edge the transfer completes and the FSM returns to IDLE.
- ACCESS with psel=0: abort. Return to IDLE, no write, no outputs asserted.

Latency:
- pready rises in access cycle WAIT_STATES+1, counting the first penable=1 cycle as 1.
- WAIT_STATES=0 gives a zero-wait two-cycle APB transfer.

Write commit:
- On the completing edge, if latched pwrite=1 and err=0: for each lane i with pstrb[i]=1, reg[index][8i+7:8i] = pwdata[8i+7:8i]. Lanes with pstrb[i]=0 are unchanged.
- pwdata and pstrb are sampled at the completing edge.
- err=1: no register changes.

Read data:
- prdata = reg[index] only while pready=1, latched pwrite=0 and err=0; otherwise prdata = 0.
- pstrb is ignored on reads.

Error:
- pslverr = pready & err.
- pslverr is 0 in every cycle where pready=0.

Back-to-back transfers:
- The next setup phase is accepted in the cycle right after completion (the FSM is back in IDLE).
- Read-after-write to the same index returns the newly written data.

Address fields:
- Address bits above the register index are part of the index. Any nonzero upper bits make index >= NUM_REGS, so the access errors; there is no aliasing or wrap-around.

Test Plan:
- WAIT_STATES=1. Write 0xDEADBEEF to paddr 0x4 with pstrb=1111 → pready low in access cycle 1, high in cycle 2, pslverr=0. Then read 0x4 → prdata=0xDEADBEEF while pready=1, 0 otherwise.
- Partial strobe: write 0xFFFFFFFF to 0xC, then write 0x12345678 with pstrb=1010, then read 0xC → 0x12FF56FF.
- Error cases, each with pslverr=1 while pready=1, no register modified, and a read of 0x10 still returning its prior value:
  - write to 0x20 (index 8, NUM_REGS=8);
  - read from 0x6 (misaligned), which also returns prdata=0.
- Abort and reset:
  - drop psel in access cycle 1 of a write to 0x10 → FSM returns to IDLE, the register is unchanged, pready never asserted;
  - assert preset during a write's ACCESS → all registers 0, outputs 0 the next cycle.
- WAIT_STATES=0: back-to-back write 0xCAFEBABE to 0x8 immediately followed by a read of 0x8 → pready in the first access cycle of each transfer, read returns 0xCAFEBABE.
